// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer
//   Multi-precision add/subtract sequencer. Operands arrive least-significant
//   word first, one A/B word pair per accepted input handshake. Each pair goes
//   through a single shared 32-bit Sklansky adder, and the carry is chained
//   between words through carry_reg. Each result word is held in a single
//   output register. That register has valid/ready handshaking with full
//   backpressure.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, len, sub     operation request (len = words-1, sub = A-B); IDLE only
//   busy                high whenever an operation is in progress
//   in_valid/in_ready   input word handshake; a_word, b_word carry the data
//   out_valid/out_ready output word handshake; s_word carries the data,
//                       out_last marks the final word
//   done                one-cycle pulse after the final word is consumed
//   carry_out           final carry (subtract: 1 = no borrow), held until next start

module sklansky_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g_pre;
  logic [31:0] p_pre;
  logic [31:0] p_bit;
  logic [32:0] carry;

  assign p_bit = a ^ b;

  // Five prefix levels. At level gl, every bit whose gl-th index bit is set
  // merges with the top bit of the block of 2^gl bits just below it.
  // After the last level, g_pre[i]/p_pre[i] span bits [i:0].
  genvar gl, gi;
  generate
    for (gl = 0; gl < 5; gl++) begin : g_level
      logic [31:0] g_in;
      logic [31:0] p_in;
      logic [31:0] g_out;
      logic [31:0] p_out;

      if (gl == 0) begin : g_first
        assign g_in = a & b;
        assign p_in = a ^ b;
      end else begin : g_chain
        assign g_in = g_level[gl-1].g_out;
        assign p_in = g_level[gl-1].p_out;
      end

      for (gi = 0; gi < 32; gi++) begin : g_bit
        if (((gi >> gl) & 1) == 1) begin : g_merge
          localparam int J = ((gi >> gl) << gl) - 1;
          assign g_out[gi] = g_in[gi] | (p_in[gi] & g_in[J]);
          assign p_out[gi] = p_in[gi] & p_in[J];
        end else begin : g_pass
          assign g_out[gi] = g_in[gi];
          assign p_out[gi] = p_in[gi];
        end
      end
    end
  endgenerate

  assign g_pre = g_level[4].g_out;
  assign p_pre = g_level[4].p_out;

  // carry[k] is the carry into bit k: the prefix over bits [k-1:0] folded with cin.
  assign carry = {g_pre | (p_pre & {32{cin}}), cin};
  assign sum   = p_bit ^ carry[31:0];
  assign cout  = carry[32];
endmodule

module mp_add_sequencer #(
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a_word,
  input  logic [31:0]      b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      s_word,
  output logic             out_last,
  output logic             done,
  output logic             carry_out
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             sub_reg, sub_next;
  logic             carry_reg, carry_next;
  logic [31:0]      s_word_reg, s_word_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_last_reg, out_last_next;
  logic             done_reg, done_next;
  logic             carry_out_reg, carry_out_next;

  logic             accept;
  logic             consume;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_cout;

  // Subtraction is A + ~B + 1. The +1 comes from preloading carry_reg with sub.
  assign add_b = b_word ^ {32{sub_reg}};

  sklansky_adder32 u_adder (
    .a    (a_word),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A new word can be taken when the output register is empty or is being
  // drained in this same cycle.
  assign in_ready = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;

  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = out_valid_reg;
  assign s_word    = s_word_reg;
  assign out_last  = out_last_reg;
  assign done      = done_reg;
  assign carry_out = carry_out_reg;

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    sub_next       = sub_reg;
    carry_next     = carry_reg;
    s_word_next    = s_word_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    done_next      = 1'b0;
    carry_out_next = carry_out_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_RUN;
          len_next       = len;
          sub_next       = sub;
          carry_next     = sub;
          cnt_next       = '0;
          carry_out_next = 1'b0;
        end
      end

      ST_RUN: begin
        if (accept) begin
          s_word_next    = add_sum;
          out_valid_next = 1'b1;
          carry_next     = add_cout;
          if (cnt_reg == len_reg) begin
            // The counter is not advanced past len, so it never wraps.
            out_last_next  = 1'b1;
            carry_out_next = add_cout;
            state_next     = ST_FLUSH;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (consume) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
        end
      end

      ST_FLUSH: begin
        if (consume) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
          done_next      = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      cnt_reg       <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      s_word_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      carry_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      cnt_reg       <= cnt_next;
      sub_reg       <= sub_next;
      carry_reg     <= carry_next;
      s_word_reg    <= s_word_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      done_reg      <= done_next;
      carry_out_reg <= carry_out_next;
    end
  end
endmodule
